// File: rtl/mem_ctrl_pkg.sv
// Shared state encoding, arbitration modes and transfer-size helper for the
// multi-port byte-serial memory controller.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {IDLE, XFER, DRAIN, FIN} state_t;

  localparam int unsigned ARB_FIXED = 0;
  localparam int unsigned ARB_RR    = 1;

  // Byte count is len+1, clamped to the widest transfer the datapath carries.
  function automatic int unsigned xfer_bytes(input int unsigned len_m1,
                                             input int unsigned max_bytes);
    return (len_m1 + 1 > max_bytes) ? max_bytes : len_m1 + 1;
  endfunction

endpackage

// File: rtl/mem_arb.sv
// NPORT request arbiter: fixed priority or round robin. Grant is combinational;
// the round-robin pointer advances only when the controller takes the grant.
module mem_arb
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned NPORT = 2,
  parameter int unsigned ARB   = ARB_FIXED,
  parameter int unsigned PW    = (NPORT > 1) ? $clog2(NPORT) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NPORT-1:0] i_elig,
  input  logic             i_take,
  output logic [NPORT-1:0] o_gnt,
  output logic [PW-1:0]    o_idx,
  output logic             o_any
);

  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_c;

  // In fixed mode the pointer never leaves 0, so the scan is lowest-index-first.
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_c   = '0;
    for (int unsigned j = 0; j < NPORT; j++) begin
      w_c = PW'((32'(r_ptr) + j) % NPORT);
      if (!o_any && i_elig[w_c]) begin
        o_any      = 1'b1;
        o_idx      = w_c;
        o_gnt[w_c] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst)
      r_ptr <= '0;
    else if (i_take && ARB == ARB_RR)
      r_ptr <= (o_idx == PW'(NPORT - 1)) ? '0 : o_idx + 1'b1;
  end

endmodule

// File: rtl/mem_ctrl_arb.sv
// Multi-port memory controller: arbitrates NPORT ports onto a byte-wide RAM and
// serialises reads/writes of up to DW/8 bytes with a pipelined read capture.
module mem_ctrl_arb
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned NPORT  = 2,
  parameter int unsigned AW     = 32,
  parameter int unsigned DW     = 32,
  parameter int unsigned LW     = 2,
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned ARB    = ARB_FIXED
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NPORT-1:0]    req,
  input  logic [NPORT-1:0]    wr,
  input  logic [NPORT*AW-1:0] addr,
  input  logic [NPORT*DW-1:0] wdata,
  input  logic [NPORT*LW-1:0] len,
  output logic [DW-1:0]       rdata,
  output logic [NPORT-1:0]    done,
  input  logic [7:0]          ram_in,
  output logic [7:0]          ram_out,
  output logic [AW-1:0]       ram_a,
  output logic                ram_wr
);

  localparam int unsigned NB = DW / 8;
  localparam int unsigned PW = (NPORT > 1) ? $clog2(NPORT) : 1;

  state_t            r_state, w_next;
  logic [PW-1:0]     r_port, w_idx;
  logic [NPORT-1:0]  w_elig, w_gnt;
  logic              w_any, w_take, w_wr_sel, w_last, r_wr;
  logic [3:0]        r_n, r_k, w_n;
  logic [DW-1:0]     r_wsh, w_wdata_sel, r_rdata;
  logic [AW-1:0]     w_addr_sel, r_ram_a;
  logic [LW-1:0]     w_len_sel;
  logic [7:0]        r_ram_out;
  logic              r_ram_wr;
  logic [RD_LAT-1:0] r_pv;
  logic [2:0]        r_pi [RD_LAT];

  assign w_elig      = req & ~done;
  assign w_take      = (r_state == IDLE) && w_any;
  assign w_wr_sel    = |(w_gnt & wr);
  assign w_addr_sel  = addr[w_idx*AW +: AW];
  assign w_wdata_sel = wdata[w_idx*DW +: DW];
  assign w_len_sel   = len[w_idx*LW +: LW];
  assign w_n         = 4'(xfer_bytes(32'(w_len_sel), NB));
  assign w_last      = (r_k == r_n - 4'd1);

  assign rdata   = r_rdata;
  assign ram_a   = r_ram_a;
  assign ram_out = r_ram_out;
  assign ram_wr  = r_ram_wr;

  mem_arb #(.NPORT(NPORT), .ARB(ARB), .PW(PW)) u_arb (
    .clk    (clk),
    .rst    (rst),
    .i_elig (w_elig),
    .i_take (w_take),
    .o_gnt  (w_gnt),
    .o_idx  (w_idx),
    .o_any  (w_any)
  );

  always_ff @(posedge clk) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    done   = '0;
    unique case (r_state)
      IDLE:    if (w_any) w_next = XFER;
      XFER:    if (w_last) w_next = r_wr ? FIN : DRAIN;
      DRAIN:   if (r_k == 4'(RD_LAT - 1)) w_next = FIN;
      FIN: begin
        w_next       = IDLE;
        done[r_port] = 1'b1;
      end
      default: w_next = IDLE;
    endcase
  end

  // Each issued read byte carries its index down an RD_LAT-deep pipe so the
  // returning byte lands in the right lane without stalling issue.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pv <= '0;
      for (int unsigned i = 0; i < RD_LAT; i++) r_pi[i] <= '0;
    end else begin
      r_pv[0] <= (r_state == XFER) && !r_wr;
      r_pi[0] <= r_k[2:0];
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        r_pv[i] <= r_pv[i-1];
        r_pi[i] <= r_pi[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_port    <= '0;
      r_wr      <= 1'b0;
      r_n       <= '0;
      r_k       <= '0;
      r_wsh     <= '0;
      r_rdata   <= '0;
      r_ram_a   <= '0;
      r_ram_out <= '0;
      r_ram_wr  <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: if (w_take) begin
          r_port    <= w_idx;
          r_wr      <= w_wr_sel;
          r_n       <= w_n;
          r_k       <= '0;
          r_ram_a   <= w_addr_sel;
          r_ram_wr  <= w_wr_sel;
          r_ram_out <= w_wdata_sel[7:0];
          r_wsh     <= w_wdata_sel >> 8;
          if (!w_wr_sel) r_rdata <= '0;
        end
        XFER: if (w_last) begin
          r_k      <= '0;
          r_ram_wr <= 1'b0;
        end else begin
          r_k       <= r_k + 4'd1;
          r_ram_a   <= r_ram_a + AW'(1);
          r_ram_out <= r_wsh[7:0];
          r_wsh     <= r_wsh >> 8;
        end
        DRAIN: r_k <= r_k + 4'd1;
        default: ;
      endcase
      if (r_pv[RD_LAT-1]) begin
        for (int unsigned b = 0; b < NB; b++)
          if (r_pi[RD_LAT-1] == 3'(b)) r_rdata[8*b +: 8] <= ram_in;
      end
    end
  end

endmodule
